rps_round_ctrl: RTL

//  Game controller upstream of the VGA choice drawer. Debounces the play button and latches the user's move.

---
 rtl/rps_round_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl
//   Rock-paper-scissors round controller that sits in front of the VGA choice drawer.
//   It debounces the play button and latches the user's move. It predicts the user's
//   move from a learned transition table and plays the move that beats that prediction.
//   It then asks the drawer for two frames (the user move, then the computer move),
//   judges the round, updates the scores and trains the table.
// Ports
//   CLOCK_50     in   system clock (50 MHz)
//   reset_n      in   asynchronous active-low reset
//   play_n       in   raw active-low play button (asynchronous)
//   user_choice  in   00 rock, 01 scissor, 10 paper, 11 invalid
//   draw_done    in   1-cycle pulse from the drawer when a frame is complete
//   draw_start   out  1-cycle pulse; the drawer loads draw_choice/draw_player
//   draw_choice  out  move to draw
//   draw_player  out  0 user, 1 computer
//   cpu_choice   out  computer move of the current/last round
//   result       out  00 none, 01 user win, 10 cpu win, 11 tie
//   user_score   out  saturating user win count
//   cpu_score    out  saturating computer win count
//   busy         out  high whenever a round is in progress
module rps_round_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 4,
    parameter int SCORE_W         = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               play_n,
    input  logic [1:0]         user_choice,
    input  logic               draw_done,
    output logic               draw_start,
    output logic [1:0]         draw_choice,
    output logic               draw_player,
    output logic [1:0]         cpu_choice,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] user_score,
    output logic [SCORE_W-1:0] cpu_score,
    output logic               busy
);

    localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PREDICT, S_DRAW_U, S_WAIT_U, S_DRAW_C, S_WAIT_C, S_JUDGE, S_UPDATE
    } state_t;

    state_t             r_state, w_next;
    logic               r_play_s1, r_play_s2;
    logic [DB_W-1:0]    r_db_cnt;
    logic               w_play_evt;
    logic               w_accept;
    logic               w_draw_start;

    logic [1:0]         r_user_move, r_last_move, r_cpu_choice, r_draw_choice, r_result;
    logic               r_draw_player, r_have_hist;
    logic [SCORE_W-1:0] r_user_score, r_cpu_score;
    logic [CNT_W-1:0]   r_tbl [3][3];

    logic [CNT_W-1:0]   w_cnt_r, w_cnt_s, w_cnt_p, w_tgt;
    logic [1:0]         w_pred, w_beater;
    logic               w_tie, w_user_wins;

    // Button synchroniser and debounce; the counter parks at DB_MAX so a long
    // press yields a single event.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_play_s1 <= 1'b1;
            r_play_s2 <= 1'b1;
            r_db_cnt  <= '0;
        end else begin
            r_play_s1 <= play_n;
            r_play_s2 <= r_play_s1;
            if (r_play_s2)
                r_db_cnt <= '0;
            else if (r_db_cnt != DB_MAX)
                r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_play_evt = !r_play_s2 && (r_db_cnt == DB_LAST);
    assign w_accept   = w_play_evt && (user_choice != 2'b11);

    // Prediction: row of the previous move, argmax with rock>scissor>paper on ties.
    always_comb begin
        w_cnt_r = r_have_hist ? r_tbl[r_last_move][2'd0] : '0;
        w_cnt_s = r_have_hist ? r_tbl[r_last_move][2'd1] : '0;
        w_cnt_p = r_have_hist ? r_tbl[r_last_move][2'd2] : '0;
        if (w_cnt_r >= w_cnt_s && w_cnt_r >= w_cnt_p)
            w_pred = 2'b00;
        else if (w_cnt_s >= w_cnt_p)
            w_pred = 2'b01;
        else
            w_pred = 2'b10;
        case (w_pred)
            2'b00:   w_beater = 2'b10;
            2'b01:   w_beater = 2'b00;
            default: w_beater = 2'b01;
        endcase
    end

    always_comb begin
        w_tie       = (r_user_move == r_cpu_choice);
        w_user_wins = (r_user_move == 2'b00 && r_cpu_choice == 2'b01) ||
                      (r_user_move == 2'b01 && r_cpu_choice == 2'b10) ||
                      (r_user_move == 2'b10 && r_cpu_choice == 2'b00);
        w_tgt       = r_tbl[r_last_move][r_user_move];
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_draw_start = 1'b0;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_PREDICT;
            S_PREDICT: w_next = S_DRAW_U;
            S_DRAW_U: begin
                w_draw_start = 1'b1;
                w_next       = S_WAIT_U;
            end
            S_WAIT_U:  if (draw_done) w_next = S_DRAW_C;
            S_DRAW_C: begin
                w_draw_start = 1'b1;
                w_next       = S_WAIT_C;
            end
            S_WAIT_C:  if (draw_done) w_next = S_JUDGE;
            S_JUDGE:   w_next = S_UPDATE;
            S_UPDATE:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // draw_choice/draw_player are loaded one cycle ahead so they are stable
    // during the draw_start cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_user_move   <= '0;
            r_last_move   <= '0;
            r_cpu_choice  <= '0;
            r_draw_choice <= '0;
            r_draw_player <= 1'b0;
            r_result      <= '0;
            r_user_score  <= '0;
            r_cpu_score   <= '0;
            r_have_hist   <= 1'b0;
            r_tbl         <= '{default: '0};
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) r_user_move <= user_choice;
                S_PREDICT: begin
                    r_cpu_choice  <= w_beater;
                    r_draw_choice <= r_user_move;
                    r_draw_player <= 1'b0;
                end
                S_WAIT_U: if (draw_done) begin
                    r_draw_choice <= r_cpu_choice;
                    r_draw_player <= 1'b1;
                end
                S_JUDGE: begin
                    if (w_tie) begin
                        r_result <= 2'b11;
                    end else if (w_user_wins) begin
                        r_result <= 2'b01;
                        if (r_user_score != '1) r_user_score <= r_user_score + 1'b1;
                    end else begin
                        r_result <= 2'b10;
                        if (r_cpu_score != '1) r_cpu_score <= r_cpu_score + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (r_have_hist) begin
                        if (&w_tgt) begin
                            // Halve the row, then the later write to the target wins.
                            r_tbl[r_last_move][2'd0] <= r_tbl[r_last_move][2'd0] >> 1;
                            r_tbl[r_last_move][2'd1] <= r_tbl[r_last_move][2'd1] >> 1;
                            r_tbl[r_last_move][2'd2] <= r_tbl[r_last_move][2'd2] >> 1;
                            r_tbl[r_last_move][r_user_move] <= (w_tgt >> 1) + 1'b1;
                        end else begin
                            r_tbl[r_last_move][r_user_move] <= w_tgt + 1'b1;
                        end
                    end
                    r_last_move <= r_user_move;
                    r_have_hist <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign draw_start  = w_draw_start;
    assign draw_choice = r_draw_choice;
    assign draw_player = r_draw_player;
    assign cpu_choice  = r_cpu_choice;
    assign result      = r_result;
    assign user_score  = r_user_score;
    assign cpu_score   = r_cpu_score;
    assign busy        = (r_state != S_IDLE);

endmodule
